// File: rtl/mul_div_ctrl.sv
// Multiply/divide controller for the EX stage: one-cycle multiply,
// 32-cycle restoring divide, and HI/LO result hand-off with pipeline stall.
module mul_div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        stall_ext,
    output logic        stall_md,
    output logic        result_valid,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    state_e      state_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] rem_q;
    logic [4:0]  cnt_q;
    logic        sgn_q;
    logic        qneg_q;
    logic        rneg_q;

    logic [31:0] mag_a_d;
    logic [31:0] mag_b_d;
    logic [63:0] ext_a_d;
    logic [63:0] ext_b_d;
    logic [63:0] prod_d;
    logic [32:0] trial_d;
    logic        fit_d;
    logic [31:0] rem_d;
    logic [31:0] quo_d;
    logic [31:0] quo_fix_d;
    logic [31:0] rem_fix_d;

    always_comb begin
        mag_a_d = (!op[0] && src_a[31]) ? -src_a : src_a;
        mag_b_d = (!op[0] && src_b[31]) ? -src_b : src_b;
        // sign-extending to 64 bits makes one unsigned multiply serve both modes
        ext_a_d = {{32{sgn_q & a_q[31]}}, a_q};
        ext_b_d = {{32{sgn_q & b_q[31]}}, b_q};
        prod_d  = ext_a_d * ext_b_d;
        trial_d = {rem_q, a_q[31]};
        fit_d   = (trial_d >= {1'b0, b_q});
        rem_d   = fit_d ? (trial_d[31:0] - b_q) : trial_d[31:0];
        quo_d   = {a_q[30:0], fit_d};
        quo_fix_d = qneg_q ? -quo_d : quo_d;
        rem_fix_d = rneg_q ? -rem_d : rem_d;
        stall_md = rst & ((state_q == IDLE & start & ~flush)
                   | state_q == MUL | state_q == DIV);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            sgn_q        <= 1'b0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
            result_valid <= 1'b0;
            result_hi    <= '0;
            result_lo    <= '0;
        end else if (flush) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            result_valid <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sgn_q  <= ~op[0];
                        cnt_q  <= '0;
                        rem_q  <= '0;
                        qneg_q <= ~op[0] & (src_a[31] ^ src_b[31]);
                        rneg_q <= ~op[0] & src_a[31];
                        if (op[1]) begin
                            a_q     <= mag_a_d;
                            b_q     <= mag_b_d;
                            state_q <= DIV;
                        end else begin
                            a_q     <= src_a;
                            b_q     <= src_b;
                            state_q <= MUL;
                        end
                    end
                end
                MUL: begin
                    result_hi    <= prod_d[63:32];
                    result_lo    <= prod_d[31:0];
                    result_valid <= 1'b1;
                    state_q      <= DONE;
                end
                DIV: begin
                    a_q   <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_hi    <= rem_fix_d;
                        result_lo    <= quo_fix_d;
                        result_valid <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (!stall_ext) begin
                        result_valid <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
